// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall, flush and forwarding control for the 5-stage MIPS pipeline
module hazard_ctrl #(
    parameter int MDU_LAT = 4,
    parameter int MEM_TMO = 255
) (
    input  logic       ref_clk,
    input  logic       rst,
    input  logic [4:0] RsD,
    input  logic [4:0] RtD,
    input  logic [4:0] RsE,
    input  logic [4:0] RtE,
    input  logic [4:0] WriteRegE,
    input  logic [4:0] WriteRegM,
    input  logic [4:0] WriteRegW,
    input  logic       RegWriteE,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       MemtoRegE,
    input  logic       MemtoRegM,
    input  logic       BranchD,
    input  logic       PCSrcD,
    input  logic       MduStartE,
    input  logic       MemReqM,
    input  logic       MemReadyM,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushM,
    output logic       FlushW,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       ForwardAD,
    output logic       ForwardBD,
    output logic       MduBusy,
    output logic       MemErr
);
    localparam logic [1:0] IDLE = 2'd0, MEM_WAIT = 2'd1, ERR = 2'd2;

    logic [1:0] state;
    logic [7:0] wait_cnt;
    logic [3:0] mdu_cnt;
    logic       tmo, mem_stall, busy, lw_stall, br_stall, hz;

    function automatic logic hit(input logic we, input logic [4:0] wr, input logic [4:0] r);
        return we && r != 5'd0 && wr == r;
    endfunction

    // the timeout cycle itself releases the pipe while the FSM moves to ERR
    assign tmo       = state == MEM_WAIT && wait_cnt == 8'(MEM_TMO);
    assign mem_stall = MemReqM & ~MemReadyM & (state != ERR) & ~tmo;
    assign busy      = mdu_cnt != 4'd0;
    assign lw_stall  = MemtoRegE & (hit(RegWriteE, WriteRegE, RsD) | hit(RegWriteE, WriteRegE, RtD));
    assign br_stall  = BranchD & (hit(RegWriteE, WriteRegE, RsD) | hit(RegWriteE, WriteRegE, RtD) |
                       (MemtoRegM & (hit(RegWriteM, WriteRegM, RsD) | hit(RegWriteM, WriteRegM, RtD))));
    assign hz        = lw_stall | br_stall;

    // prioritised stall/flush rows, reset fills the pipe with bubbles
    always_comb begin
        StallF    = !rst && (mem_stall || busy || hz);
        StallD    = !rst && (mem_stall || busy || hz);
        StallE    = !rst && (mem_stall || busy);
        StallM    = !rst && mem_stall;
        FlushW    = rst || mem_stall;
        FlushM    = rst || (!mem_stall && busy);
        FlushE    = rst || (!mem_stall && !busy && hz);
        FlushD    = rst || (PCSrcD && !StallD);
        ForwardAE = rst ? 2'b00 : hit(RegWriteM, WriteRegM, RsE) ? 2'b10 : hit(RegWriteW, WriteRegW, RsE) ? 2'b01 : 2'b00;
        ForwardBE = rst ? 2'b00 : hit(RegWriteM, WriteRegM, RtE) ? 2'b10 : hit(RegWriteW, WriteRegW, RtE) ? 2'b01 : 2'b00;
        ForwardAD = !rst && hit(RegWriteM, WriteRegM, RsD) && !MemtoRegM;
        ForwardBD = !rst && hit(RegWriteM, WriteRegM, RtD) && !MemtoRegM;
        MduBusy   = !rst && busy;
        MemErr    = !rst && state == ERR;
    end

    // memory wait handshake with timeout into a sticky error state
    always_ff @(posedge ref_clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= 8'd0;
        end else if (state == IDLE) begin
            if (mem_stall) begin
                state    <= MEM_WAIT;
                wait_cnt <= 8'd1;
            end
        end else if (state == MEM_WAIT) begin
            if (MemReadyM || !MemReqM) state <= IDLE;
            else if (tmo) state <= ERR;
            else wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // fixed-latency mult/div hold counter, keeps counting through memory stalls
    always_ff @(posedge ref_clk) begin
        if (rst) mdu_cnt <= 4'd0;
        else if (MduStartE && !mem_stall && !busy) mdu_cnt <= 4'(MDU_LAT);
        else if (busy) mdu_cnt <= mdu_cnt - 4'd1;
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vector and sequence checks for hazard_ctrl
module tb_hazard_ctrl;
    logic       ref_clk = 1'b0;
    logic       rst;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
    logic       BranchD, PCSrcD, MduStartE, MemReqM, MemReadyM;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW;
    logic [1:0] ForwardAE, ForwardBE;
    logic       ForwardAD, ForwardBD, MduBusy, MemErr;
    logic [15:0] outv;
    int applied = 0;
    int fails = 0;

    typedef struct {
        logic [4:0]  rsd, rtd, rse, rte, wre, wrm, wrw;
        logic [6:0]  ctl;
        logic [15:0] ex;
    } vec_t;
    vec_t vq[$];

    hazard_ctrl #(.MDU_LAT(4), .MEM_TMO(4)) dut (
        .ref_clk(ref_clk), .rst(rst),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
        .BranchD(BranchD), .PCSrcD(PCSrcD), .MduStartE(MduStartE),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .MduBusy(MduBusy), .MemErr(MemErr)
    );

    always #5 ref_clk = ~ref_clk;

    assign outv = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW,
                   ForwardAE, ForwardBE, ForwardAD, ForwardBD, MduBusy, MemErr};

    task automatic chk(input string nm, input logic [15:0] mask, input logic [15:0] ex);
        applied++;
        if ((outv & mask) !== (ex & mask)) begin
            fails++;
            $display("FAIL %s: got %h expected %h (mask %h)", nm, outv, ex, mask);
        end
    endtask

    task automatic step(input string nm, input logic [15:0] mask, input logic [15:0] ex);
        @(negedge ref_clk);
        chk(nm, mask, ex);
        @(posedge ref_clk);
        #1;
    endtask

    task automatic clr();
        {RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW} = '0;
        {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD, PCSrcD} = '0;
        {MduStartE, MemReqM, MemReadyM} = '0;
    endtask

    task automatic add(input logic [4:0] rsd, rtd, rse, rte, wre, wrm, wrw,
                       input logic [6:0] ctl, input logic [15:0] ex);
        vq.push_back('{rsd, rtd, rse, rte, wre, wrm, wrw, ctl, ex});
    endtask

    initial begin
        // ctl = {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD, PCSrcD}
        add(0, 0, 0, 0, 0, 0, 0, 7'b0000000, 16'h0000);
        add(0, 0, 5, 0, 0, 5, 5, 7'b0110000, 16'h0080);
        add(0, 0, 5, 0, 0, 5, 5, 7'b0010000, 16'h0040);
        add(0, 0, 5, 0, 0, 0, 0, 7'b0110000, 16'h0000);
        add(0, 0, 0, 9, 0, 0, 9, 7'b0010000, 16'h0010);
        add(0, 0, 0, 0, 0, 0, 0, 7'b0110000, 16'h0000);
        add(0, 0, 4, 4, 0, 4, 0, 7'b0100000, 16'h00A0);
        add(0, 0, 2, 3, 0, 3, 2, 7'b0110000, 16'h0060);
        add(6, 0, 0, 0, 0, 6, 0, 7'b0100000, 16'h0008);
        add(6, 0, 0, 0, 0, 6, 0, 7'b0100100, 16'h0000);
        add(0, 6, 0, 0, 0, 6, 0, 7'b0100000, 16'h0004);
        add(3, 0, 0, 0, 3, 0, 0, 7'b1001000, 16'hC400);
        add(3, 0, 0, 0, 0, 0, 0, 7'b1001000, 16'h0000);
        add(0, 3, 0, 0, 3, 0, 0, 7'b1001000, 16'hC400);
        add(3, 0, 0, 0, 3, 0, 0, 7'b0001000, 16'h0000);
        add(0, 0, 0, 0, 0, 0, 0, 7'b1001000, 16'h0000);
        add(0, 7, 0, 0, 7, 0, 0, 7'b1000010, 16'hC400);
        add(0, 7, 0, 0, 0, 0, 0, 7'b0000011, 16'h0800);
        add(8, 0, 0, 0, 0, 8, 0, 7'b0100110, 16'hC400);
        add(8, 0, 0, 0, 0, 8, 0, 7'b0100010, 16'h0008);
        add(0, 7, 0, 0, 7, 0, 0, 7'b1000011, 16'hC400);
        add(0, 0, 0, 0, 0, 0, 0, 7'b0000001, 16'h0800);
        add(7, 0, 0, 0, 7, 0, 0, 7'b0000010, 16'h0000);

        clr();
        rst = 1'b1;
        RsE = 5; RegWriteM = 1; WriteRegM = 5; PCSrcD = 1; MduStartE = 1; MemReqM = 1;
        repeat (2) begin
            @(negedge ref_clk);
            chk("reset", 16'hFFFF, 16'h0F00);
        end
        @(posedge ref_clk);
        #1;
        rst = 1'b0;
        clr();
        step("idle", 16'hFFFF, 16'h0000);

        foreach (vq[i]) begin
            {RsD, RtD, RsE, RtE} = {vq[i].rsd, vq[i].rtd, vq[i].rse, vq[i].rte};
            {WriteRegE, WriteRegM, WriteRegW} = {vq[i].wre, vq[i].wrm, vq[i].wrw};
            {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD, PCSrcD} = vq[i].ctl;
            step($sformatf("vec%0d", i), 16'hFFFF, vq[i].ex);
        end
        clr();

        MemReqM = 1;
        repeat (3) step("mem_wait", 16'hFFFF, 16'hF100);
        MemReadyM = 1;
        step("mem_ready", 16'hFFFF, 16'h0000);
        MemReqM = 0; MemReadyM = 0;
        step("mem_idle", 16'hFFFF, 16'h0000);
        MemReqM = 1; MemReadyM = 1;
        step("zero_wait", 16'hFFFF, 16'h0000);

        MemReadyM = 0; MduStartE = 1;
        step("mdu_blocked", 16'hFFFF, 16'hF100);
        MemReadyM = 1;
        step("mdu_start_after_mem", 16'hFFFF, 16'h0000);
        MemReqM = 0; MemReadyM = 0; MduStartE = 0;
        repeat (4) step("mdu_busy", 16'hFFFF, 16'hE202);
        step("mdu_free", 16'hFFFF, 16'h0000);

        MduStartE = 1;
        step("mdu_c10", 16'hFFFF, 16'h0000);
        MduStartE = 0;
        step("mdu_c11", 16'hFFFF, 16'hE202);
        MemReqM = 1;
        step("mdu_c12_mem", 16'hFFFF, 16'hF102);
        MemReadyM = 1;
        step("mdu_c13", 16'hFFFF, 16'hE202);
        MemReqM = 0; MemReadyM = 0;
        step("mdu_c14", 16'hFFFF, 16'hE202);
        step("mdu_c15", 16'hFFFF, 16'h0000);

        MduStartE = 1;
        step("mdu2_c10", 16'hFFFF, 16'h0000);
        MduStartE = 0;
        step("mdu2_c11", 16'hFFFF, 16'hE202);
        step("mdu2_c12", 16'hFFFF, 16'hE202);
        rst = 1;
        step("mdu2_c13_rst", 16'hFFFF, 16'h0F00);
        rst = 0;
        step("mdu2_c14", 16'hFFFF, 16'h0000);

        MemReqM = 1;
        repeat (4) step("tmo_wait", 16'hFFFF, 16'hF100);
        step("tmo_release", 16'hF000, 16'h0000);
        step("tmo_err", 16'hFFFF, 16'h0001);
        MemReqM = 0;
        step("err_sticky", 16'hFFFF, 16'h0001);
        rst = 1;
        step("err_rst", 16'hFFFF, 16'h0F00);
        rst = 0;
        step("err_cleared", 16'hFFFF, 16'h0000);
        MemReqM = 1;
        step("mem_after_rst", 16'hFFFF, 16'hF100);

        $display("== %0d vectors applied, %0d miscompares ==", applied, fails);
        $finish;
    end
endmodule
